// File: rtl/pipe_drain_fifo.sv
`default_nettype none
// ============================================================================
// Module      : pipe_drain_fifo
// Description : Credit-gated FWFT drain buffer behind a fixed-latency,
//               never-stalling compute pipeline.
// Revision    : 1.0 - initial release
// ============================================================================
module pipe_drain_fifo #(
    parameter int LATENCY    = 7,
    parameter int DATA_WIDTH = 8,
    parameter int DEPTH      = 16
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           in_valid,
    output logic                           in_ready,
    output logic                           issue,
    input  logic                           pipe_valid,
    input  logic [DATA_WIDTH-1:0]          pipe_data,
    output logic                           out_valid,
    output logic [DATA_WIDTH-1:0]          out_data,
    input  logic                           out_ready,
    output logic [$clog2(DEPTH+1)-1:0]     count,
    output logic [$clog2(DEPTH+1)-1:0]     inflight,
    output logic                           err
);

    localparam int CW     = $clog2(DEPTH + 1);
    localparam int PW     = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int DM1    = DEPTH - 1;
    localparam int DEPTHV = DEPTH;

    localparam logic [PW-1:0] C_LAST_PTR = DM1[PW-1:0];
    localparam logic [CW-1:0] C_FULL     = DEPTHV[CW-1:0];
    localparam logic [CW:0]   C_CREDITS  = DEPTHV[CW:0];

    if (DEPTH < 1 || LATENCY < 1) begin : g_param_check
        $error("pipe_drain_fifo: DEPTH and LATENCY must both be at least 1");
    end

    logic [DATA_WIDTH-1:0] mem_q [DEPTH];
    logic [PW-1:0]         rd_ptr_q;
    logic [PW-1:0]         rd_ptr_d;
    logic [PW-1:0]         wr_ptr_q;
    logic [PW-1:0]         wr_ptr_d;
    logic [CW-1:0]         count_q;
    logic [CW-1:0]         count_d;
    logic [CW-1:0]         inflight_q;
    logic [CW-1:0]         inflight_d;
    logic                  err_q;
    logic                  err_d;

    logic                  w_issue;
    logic                  w_pop;
    logic                  w_full;
    logic                  w_orphan;
    logic                  w_ovf;
    logic                  w_ret;
    logic                  w_push;
    logic [CW:0]           w_credit_sum;

    function automatic logic [PW-1:0] f_next_ptr(input logic [PW-1:0] p);
        return (p == C_LAST_PTR) ? '0 : p + PW'(1);
    endfunction

    // Credits count both buffered and in-flight tokens, from registers only,
    // so the pipeline output and consumer never feed back combinationally.
    assign w_credit_sum = {1'b0, count_q} + {1'b0, inflight_q};
    assign in_ready     = !rst && (w_credit_sum < C_CREDITS);
    assign w_issue      = in_valid && in_ready;
    assign issue        = w_issue;

    assign out_valid    = !rst && (count_q != '0);
    assign out_data     = mem_q[rd_ptr_q];
    assign w_pop        = out_valid && out_ready;

    // A return with nothing outstanding, or into a full buffer that is not
    // being popped, is dropped and flagged.
    assign w_full       = (count_q == C_FULL);
    assign w_orphan     = pipe_valid && (inflight_q == '0);
    assign w_ovf        = pipe_valid && w_full && !w_pop;
    assign w_ret        = pipe_valid && !w_orphan;
    assign w_push       = pipe_valid && !w_orphan && !w_ovf;

    always_comb begin
        inflight_d = inflight_q;
        case ({w_issue, w_ret})
            2'b10:   inflight_d = inflight_q + CW'(1);
            2'b01:   inflight_d = inflight_q - CW'(1);
            default: inflight_d = inflight_q;
        endcase
    end

    always_comb begin
        count_d = count_q;
        case ({w_push, w_pop})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
    end

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (w_push) begin
            wr_ptr_d = f_next_ptr(wr_ptr_q);
        end
        if (w_pop) begin
            rd_ptr_d = f_next_ptr(rd_ptr_q);
        end
    end

    assign err_d = err_q || w_orphan || w_ovf;

    always_ff @(posedge clk) begin
        if (rst) begin
            rd_ptr_q   <= '0;
            wr_ptr_q   <= '0;
            count_q    <= '0;
            inflight_q <= '0;
            err_q      <= 1'b0;
        end else begin
            rd_ptr_q   <= rd_ptr_d;
            wr_ptr_q   <= wr_ptr_d;
            count_q    <= count_d;
            inflight_q <= inflight_d;
            err_q      <= err_d;
        end
    end

    // Storage is deliberately left uncleared by reset; pointers gate visibility.
    always_ff @(posedge clk) begin
        if (w_push && !rst) begin
            mem_q[wr_ptr_q] <= pipe_data;
        end
    end

    assign count    = count_q;
    assign inflight = inflight_q;
    assign err      = err_q;

endmodule
`default_nettype wire
